// File: rtl/mips32_pkg.sv
// Shared mips32 definitions for the multiply/divide unit: op codes, FSM states,
// iteration count and the operand magnitude helper.
package mips32_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_ITERS = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_t;

    // Two's complement magnitude; 32'h80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] v,
                                                     input logic is_signed);
        return (is_signed && v[MDU_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Multiply and divide share one 64-bit accumulator, the counter and FIX negation.
module mult_div_unit
    import mips32_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    localparam logic [4:0] LAST_ITER = 5'(MDU_ITERS - 1);

    mdu_state_t         state;
    mdu_state_t         state_next;
    mdu_op_t            op_q;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               sign_a;
    logic               sign_b;
    logic               busy_q;
    logic               done_q;

    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic               div_q;
    logic               signed_q;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign in_signed = ~bus.op[0];
    assign in_div    = bus.op[1];
    assign mag_a     = mdu_mag(bus.a, in_signed);
    assign mag_b     = mdu_mag(bus.b, in_signed);

    assign div_q    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign signed_q = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign neg_res  = signed_q & (sign_a ^ sign_b);
    assign neg_rem  = signed_q & sign_a;

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (bus.start) state_next = MDU_RUN;
            MDU_RUN:  if (cnt == LAST_ITER) state_next = MDU_FIX;
            MDU_FIX:  state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MDU_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != MDU_IDLE);
            done_q <= (state == MDU_FIX);
        end
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
    // Divide: acc = {partial remainder, dividend/quotient bits}, shift left;
    // the remainder is widened by one bit so the trial compare cannot overflow.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge  = (div_rem >= {1'b0, opnd});
        rem_sub = div_rem[WIDTH-1:0] - opnd;
        if (div_q) begin
            acc_step = {(div_ge ? rem_sub : div_rem[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = neg_res ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (opnd == '0) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem ? -rem : rem;
                fix_lo = neg_res ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= MDU_MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (bus.start) begin
                        op_q   <= mdu_op_t'(bus.op);
                        cnt    <= '0;
                        a_raw  <= bus.a;
                        sign_a <= bus.a[WIDTH-1];
                        sign_b <= bus.b[WIDTH-1];
                        opnd   <= in_div ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                MDU_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                end
                MDU_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO
// and done cycle; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        sb[$];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", 64'(bus.hi), 64'(e.hi));
                check("result_lo", 64'(bus.lo), 64'(e.lo));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a rising edge; returns just after the next one (T+1).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input bit keep,
                         output int unsigned t);
        exp_t e;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        t = cyc;
        if (keep) begin
            e.hi = eh; e.lo = el; e.cyc = cyc + 34;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        logic [33:0] busy_v;
        logic [33:0] done_v;
        logic [33:0] busy_exp;
        logic [33:0] done_exp;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(bus.hi), 64'h0);
        check("reset_lo", 64'(bus.lo), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_done", 64'(bus.done), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MULTU max x max, with the busy/done window recorded cycle by cycle.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, t);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            busy_v[k] = bus.busy;
            done_v[k] = bus.done;
        end
        busy_exp = '0;
        done_exp = '0;
        for (int k = 0; k < 33; k++) busy_exp[k] = 1'b1;
        done_exp[33] = 1'b1;
        check("busy_window", 64'(busy_v), 64'(busy_exp));
        check("done_window", 64'(done_v), 64'(done_exp));
        @(posedge clk); #1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, t);
        wait_until(t + 34);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1, t);
        wait_until(t + 34);

        // DIV -7/2 with a stray start and mthi during RUN.
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, t);
        wait_until(t + 5);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7;
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        check("run_mthi_hi", 64'(bus.hi), 64'h4000_0000);
        check("run_busy", 64'(bus.busy), 64'h1);
        wait_until(t + 34);

        issue(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, t);
        wait_until(t + 34);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1, t);
        wait_until(t + 34);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b1, t);
        wait_until(t + 34);

        // Idle MTHI+MTLO together.
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'hA5A5_A5A5);
        check("mtlo_lo", 64'(bus.lo), 64'hA5A5_A5A5);
        check("mt_no_done", 64'(bus.done), 64'h0);

        // start + mtlo: the write is dropped.
        bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
        issue(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b1, t);
        bus.mtlo = 1'b0;
        check("start_mtlo_lo", 64'(bus.lo), 64'hA5A5_A5A5);
        wait_until(t + 34);
        bus.mthi = 1'b1; bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        check("mthi_after_done", 64'(bus.hi), 64'hCAFE_F00D);

        // Asynchronous reset in the middle of a DIVU.
        issue(2'b11, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, t);
        wait_until(t + 10);
        reset = 1'b1;
        #1;
        check("async_rst_hi", 64'(bus.hi), 64'h0);
        check("async_rst_lo", 64'(bus.lo), 64'h0);
        check("async_rst_busy", 64'(bus.busy), 64'h0);
        check("async_rst_done", 64'(bus.done), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: second start issued in the done cycle of the first.
        issue(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1'b1, t);
        wait_until(t + 34);
        issue(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b1, t);
        check("b2b_busy", 64'(bus.busy), 64'h1);
        wait_until(t + 34);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the mips32 core, implementing MULT, MULTU, DIV, DIVU, MTHI and MTLO with architectural HI/LO registers. It sits in the EX stage beside the ALU. Its `hi`/`lo` outputs feed the third input of the writeback 3:1 result mux for MFHI and MFLO. `busy` goes to the hazard unit, which stalls the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launches the operation in `op`. Sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand or dividend).
- `b`  in  WIDTH  rt operand (multiplier or divisor).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  data for MTHI and MTLO.
- `hi`  out  WIDTH  HI register. Reset value 0.
- `lo`  out  WIDTH  LO register. Reset value 0.
- `busy`  out  1  high while an operation is in progress. Reset value 0.
- `done`  out  1  one-cycle pulse in the first cycle the new HI/LO values are visible. Reset value 0.

## Operation
- FSM states:
  - IDLE: accepts `start`, `mthi` and `mtlo`.
  - RUN: 32 iterations, tracked by a 5-bit counter.
  - FIX: applies sign correction and writes HI/LO.
- Transitions: IDLE to RUN on `start`. RUN to FIX when the counter reaches 31. FIX to IDLE unconditionally.
- On `start`:
  - latch the operand magnitudes: absolute value for MULT and DIV, raw value for the unsigned ops;
  - latch the result-sign flags and the op.
- Multiply: shift-add on a 64-bit accumulator, one multiplier bit per RUN cycle.
  - Signed product is negated in FIX iff the signs of `a` and `b` differ.
  - HI receives the upper 32 bits and LO the lower 32 bits.
- Divide: restoring division, one quotient bit per RUN cycle. LO receives the quotient and HI the remainder.
  - Signed case: the quotient is negative iff the operand signs differ, and the remainder takes the sign of `a`.
- Divide by zero (both DIV and DIVU): LO = 32'hFFFFFFFF, HI = `a` unchanged. No exception is raised.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- MTHI/MTLO are honoured only in IDLE.
  - If either is asserted together with `start`, `start` wins and the write is dropped.
  - `mthi` and `mtlo` together both write `wdata`.
- `start`, `mthi` and `mtlo` are ignored in RUN and FIX. HI/LO hold their old values until FIX completes.
- `reset` at any time, including mid-operation:
  - FSM returns to IDLE immediately;
  - HI, LO, the counter and the accumulators clear to 0;
  - `busy` and `done` go to 0.

## Timing
- `start` is sampled in cycle T. In cycles T+1 through T+33, `busy` = 1: 32 RUN cycles, then 1 FIX cycle.
- HI/LO are written at the edge ending T+33.
- In cycle T+34, new HI/LO are visible, `done` = 1 and `busy` = 0. Total latency is 34 cycles.
- A new `start` may be accepted in T+34 itself (back-to-back operation).
- MTHI/MTLO asserted in cycle T are visible on `hi`/`lo` in T+1. `done` does not pulse for these writes.
- `hi` and `lo` are direct register outputs, with no combinational path from inputs.
- `busy` is a registered output (state != IDLE).

## Structure
- Shared package `mips32_pkg` holds:
  - op codes: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - FSM state encoding: MDU_IDLE, MDU_RUN, MDU_FIX;
  - the iteration count constant MDU_ITERS = 32.
- Single module with no sub-modules. The multiply and divide datapaths share the 64-bit accumulator, the counter and the FIX negation logic.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF, start at T → HI = 32'hFFFFFFFE, LO = 32'h00000001, with `done` high only in T+34 and `busy` high in T+1 through T+33.
- MULT −3 × 5 → HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1. Then MULT 32'h80000000 × 32'h80000000 → HI = 32'h40000000, LO = 0.
- Divide cases:
  - DIV −7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF.
  - DIVU 7 / 0 → LO = 32'hFFFFFFFF, HI = 7.
  - DIV 32'h80000000 / 32'hFFFFFFFF → LO = 32'h80000000, HI = 0.
- Ignored-input rules:
  - `start` at T+5 with different operands → ignored, original result delivered at T+34.
  - `mthi` during RUN → HI unchanged.
  - In IDLE, `mthi` + `mtlo` with `wdata` = 32'hA5A5A5A5 → both registers read 32'hA5A5A5A5 the next cycle.
  - `start` + `mtlo` together → operation runs, LO is not written with `wdata`.
- `reset` asserted at T+10 of a DIVU → `hi`, `lo`, `busy` and `done` go to 0 without waiting for a clock edge. After release, MULTU 6 × 7 → LO = 42, HI = 0 after 34 cycles.
- Back-to-back: a second MULTU 2 × 3 started in the `done` cycle → LO = 6 exactly 34 cycles later, with no idle gap between the two operations.
